// File: rtl/vga_sram_arbiter_if.sv
// SRAM pin bundle between the VGA frame-buffer arbiter and the pad ring.
// Master drives address/strobes/data; slave returns read data.
interface vga_sram_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_ub_n;
  logic              sram_lb_n;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_in;

  modport master (
    output sram_addr, sram_we_n, sram_oe_n,
    output sram_ub_n, sram_lb_n,
    output sram_dq_out, sram_dq_oe,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr, sram_we_n, sram_oe_n,
    input  sram_ub_n, sram_lb_n,
    input  sram_dq_out, sram_dq_oe,
    output sram_dq_in
  );
endinterface

// File: rtl/vga_sram_arbiter.sv
// VGA frame SRAM arbiter: display reads win, buffered writes drain in window.
// Optional stall/drop counters are enabled by VGA_ARB_STATS_EN.
module vga_sram_arbiter #(
  parameter int H_RES      = 800,
  parameter int V_RES      = 600,
  parameter int ADDR_W     = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       disp_active,
  input  logic       wr_window,
  input  logic       disp_rd,
  input  logic [9:0] disp_x,
  input  logic [9:0] disp_y,
  output logic [7:0] disp_rdata,
  output logic       disp_rvalid,
  input  logic       wr_req,
  input  logic [9:0] wr_x,
  input  logic [9:0] wr_y,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  vga_sram_arbiter_if.master sram,
  output logic       err_collision
`ifdef VGA_ARB_STATS_EN
  ,
  output logic [15:0] wr_stall_cnt,
  output logic [7:0]  wr_drop_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] word;
    logic              lane;
    logic [7:0]        data;
    logic              oor;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  function automatic logic [18:0] pix_idx(
    input logic [9:0] x,
    input logic [9:0] y
  );
    return 19'(y) * 19'(H_RES) + 19'(x);
  endfunction

  function automatic logic out_rng(
    input logic [9:0] x,
    input logic [9:0] y
  );
    return (x >= 10'(H_RES)) || (y >= 10'(V_RES));
  endfunction

  state_t state, state_d;

  logic [18:0] rd_idx, wr_idx;
  logic        rd_go, in_wr;
  logic        ld_rd, ld_wr, pop, push;
  logic        full, empty;
  logic [PW:0] wptr, rptr;
  entry_t      fifo_q [FIFO_DEPTH];
  entry_t      head;

  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       dq_q;
  logic              lane_q;
  logic              p1_v, p1_zero, p1_lane;
  logic              oe_n, we_n, ub_n, lb_n;

  assign rd_idx = pix_idx(disp_x, disp_y);
  assign wr_idx = pix_idx(wr_x, wr_y);
  assign rd_go  = disp_rd && disp_active;
  assign in_wr  = (state == WR_SETUP) ||
                  (state == WR_PULSE) ||
                  (state == WR_HOLD);

  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) &&
                 (wptr[PW-1:0] == rptr[PW-1:0]);
  assign wr_ready = !full;
  assign push  = wr_req && wr_ready;
  assign head  = fifo_q[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        fifo_q[i] <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr[PW-1:0]] <= '{
          word: wr_idx[ADDR_W:1],
          lane: wr_idx[0],
          data: wr_data,
          oor:  out_rng(wr_x, wr_y)
        };
        wptr <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  // Strobes decode straight from state so reset releases them at once
  always_comb begin
    state_d = state;
    ld_rd   = 1'b0;
    ld_wr   = 1'b0;
    pop     = 1'b0;
    oe_n    = 1'b1;
    we_n    = 1'b1;
    ub_n    = 1'b1;
    lb_n    = 1'b1;
    unique case (state)
      IDLE: begin
        if (rd_go) begin
          state_d = RD;
          ld_rd   = 1'b1;
        end else if (!empty && wr_window && !disp_active) begin
          if (head.oor) begin
            pop = 1'b1;
          end else begin
            state_d = WR_SETUP;
            ld_wr   = 1'b1;
          end
        end
      end
      RD: begin
        oe_n = 1'b0;
        ub_n = 1'b0;
        lb_n = 1'b0;
        if (rd_go) begin
          ld_rd = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR_SETUP: begin
        ub_n    = !lane_q;
        lb_n    = lane_q;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        we_n    = 1'b0;
        ub_n    = !lane_q;
        lb_n    = lane_q;
        state_d = WR_HOLD;
      end
      WR_HOLD: begin
        ub_n    = !lane_q;
        lb_n    = lane_q;
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr_q        <= '0;
      dq_q          <= '0;
      lane_q        <= 1'b0;
      p1_v          <= 1'b0;
      p1_zero       <= 1'b0;
      p1_lane       <= 1'b0;
      disp_rvalid   <= 1'b0;
      disp_rdata    <= '0;
      err_collision <= 1'b0;
    end else begin
      state <= state_d;
      if (ld_rd)
        addr_q <= rd_idx[ADDR_W:1];
      if (ld_wr) begin
        addr_q <= head.word;
        lane_q <= head.lane;
        dq_q   <= head.lane ? {head.data, 8'h00}
                            : {8'h00, head.data};
      end
      p1_v        <= rd_go;
      p1_zero     <= out_rng(disp_x, disp_y) || in_wr;
      p1_lane     <= rd_idx[0];
      disp_rvalid <= p1_v;
      if (p1_v)
        disp_rdata <= p1_zero ? 8'h00 :
                      p1_lane ? sram.sram_dq_in[15:8]
                              : sram.sram_dq_in[7:0];
      if (rd_go && in_wr)
        err_collision <= 1'b1;
    end
  end

  assign sram.sram_addr   = addr_q;
  assign sram.sram_we_n   = we_n;
  assign sram.sram_oe_n   = oe_n;
  assign sram.sram_ub_n   = ub_n;
  assign sram.sram_lb_n   = lb_n;
  assign sram.sram_dq_out = dq_q;
  assign sram.sram_dq_oe  = in_wr;

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_stall_cnt <= '0;
      wr_drop_cnt  <= '0;
    end else begin
      if (wr_req && !wr_ready && (wr_stall_cnt != 16'hFFFF))
        wr_stall_cnt <= wr_stall_cnt + 16'd1;
      if (pop && head.oor && (wr_drop_cnt != 8'hFF))
        wr_drop_cnt <= wr_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Bench for vga_sram_arbiter: SRAM model, read/write scoreboards.
// Directed reads, FIFO fill/drain, discard, collision, reset mid-write.
module tb_vga_sram_arbiter;

  localparam int HR = 800;
  localparam int VR = 600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disp_active, wr_window, disp_rd, wr_req;
  logic [9:0] disp_x, disp_y, wr_x, wr_y;
  logic [7:0] wr_data, disp_rdata;
  logic       disp_rvalid, wr_ready, err;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_cnt;
  logic [7:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  vga_sram_arbiter_if #(.ADDR_W(18)) sif ();

  logic [15:0] mem [0:262143];
  assign sif.sram_dq_in = mem[sif.sram_addr];

  vga_sram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .disp_active  (disp_active),
    .wr_window    (wr_window),
    .disp_rd      (disp_rd),
    .disp_x       (disp_x),
    .disp_y       (disp_y),
    .disp_rdata   (disp_rdata),
    .disp_rvalid  (disp_rvalid),
    .wr_req       (wr_req),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .sram         (sif.master),
    .err_collision(err)
`ifdef VGA_ARB_STATS_EN
    ,
    .wr_stall_cnt (stall_cnt),
    .wr_drop_cnt  (drop_cnt)
`endif
  );

  typedef struct { int due; logic [7:0] d; } rd_t;
  typedef struct { int word; bit lane; logic [7:0] d; } wr_t;

  rd_t rq[$];
  wr_t wq[$];
  int  compared = 0;
  int  mism = 0;
  int  cyc = 0;
  int  mcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    int idx;
    if (x >= HR || y >= VR) return 8'h00;
    idx = y * HR + x;
    return (idx % 2) ? mem[idx / 2][15:8] : mem[idx / 2][7:0];
  endfunction

  task automatic rd(input int x, input int y, input bit coll);
    disp_rd = 1'b1;
    disp_x  = 10'(x);
    disp_y  = 10'(y);
    if (disp_active)
      rq.push_back('{cyc + 2, coll ? 8'h00 : pix(x, y)});
  endtask

  task automatic wpush(input int x, input int y, input logic [7:0] d);
    int idx;
    chk("wr_ready", wr_ready, 32'(mcnt < 4));
    wr_req  = 1'b1;
    wr_x    = 10'(x);
    wr_y    = 10'(y);
    wr_data = d;
    if (mcnt < 4) begin
      mcnt++;
      idx = y * HR + x;
      if (x < HR && y < VR)
        wq.push_back('{idx / 2, bit'(idx % 2), d});
    end
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  task automatic wait_we();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sif.sram_we_n == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_we_timeout", 32'(ok), 1);
  endtask

  // SRAM model plus per-cycle compare against the scoreboards
  initial begin
    bit  prev_we = 1'b1;
    bit  prev_dqoe = 1'b0;
    bit  hold = 1'b0;
    bit  exp_v;
    wr_t e;
    for (int i = 0; i < 262144; i++)
      mem[i] = {8'(i) ^ 8'h3C, 8'(i)};
    mem[1] = 16'hAB12;
    forever begin
      @(negedge clk);
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rvalid", disp_rvalid, 32'(exp_v));
      if (exp_v) begin
        chk("rdata", disp_rdata, rq[0].d);
        void'(rq.pop_front());
      end
      if (!rst_n) begin
        prev_we   = 1'b1;
        prev_dqoe = 1'b0;
        hold      = 1'b0;
      end else begin
        if (!sif.sram_oe_n) begin
          chk("oe_vs_we", sif.sram_we_n, 1);
          chk("oe_vs_dq_oe", sif.sram_dq_oe, 0);
        end
        if (hold) begin
          chk("hold_dq_oe", sif.sram_dq_oe, 1);
          chk("hold_we_n", sif.sram_we_n, 1);
          hold = 1'b0;
        end
        if (!sif.sram_we_n) begin
          chk("we_single_cycle", 32'(prev_we), 1);
          chk("setup_dq_oe", 32'(prev_dqoe), 1);
          chk("pulse_dq_oe", sif.sram_dq_oe, 1);
          chk("we_expected", 32'(wq.size() != 0), 1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr", sif.sram_addr, e.word);
            chk("wr_ub_n", sif.sram_ub_n, 32'(!e.lane));
            chk("wr_lb_n", sif.sram_lb_n, 32'(e.lane));
            chk("wr_dq", sif.sram_dq_out,
                e.lane ? {e.d, 8'h00} : {8'h00, e.d});
          end
          if (!sif.sram_ub_n)
            mem[sif.sram_addr][15:8] = sif.sram_dq_out[15:8];
          if (!sif.sram_lb_n)
            mem[sif.sram_addr][7:0] = sif.sram_dq_out[7:0];
          hold = 1'b1;
        end
        prev_we   = sif.sram_we_n;
        prev_dqoe = sif.sram_dq_oe;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b1;
    disp_active = 1'b0;
    wr_window   = 1'b0;
    disp_rd     = 1'b0;
    wr_req      = 1'b0;
    disp_x      = '0;
    disp_y      = '0;
    wr_x        = '0;
    wr_y        = '0;
    wr_data     = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we_n", sif.sram_we_n, 1);
    chk("rst_oe_n", sif.sram_oe_n, 1);
    chk("rst_ub_n", sif.sram_ub_n, 1);
    chk("rst_lb_n", sif.sram_lb_n, 1);
    chk("rst_dq_oe", sif.sram_dq_oe, 0);
    chk("rst_addr", sif.sram_addr, 0);
    chk("rst_dq_out", sif.sram_dq_out, 0);
    chk("rst_rdata", disp_rdata, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wr_ready", wr_ready, 1);
    chk("idle_oe_n", sif.sram_oe_n, 1);

    // back-to-back reads, pinned by literal values
    disp_active = 1'b1;
    rd(3, 0, 1'b0);
    @(negedge clk);
    chk("rd0_addr", sif.sram_addr, 1);
    chk("rd0_oe_n", sif.sram_oe_n, 0);
    chk("rd0_masks", {sif.sram_ub_n, sif.sram_lb_n}, 0);
    chk("rd0_lat1_rvalid", disp_rvalid, 0);
    rd(2, 0, 1'b0);
    @(negedge clk);
    chk("rd0_data_AB", disp_rdata, 8'hAB);
    chk("rd1_addr", sif.sram_addr, 1);
    rd(5, 1, 1'b0);
    @(negedge clk);
    chk("rd1_data_12", disp_rdata, 8'h12);
    chk("rd2_addr", sif.sram_addr, 402);
    rd(900, 0, 1'b0);
    @(negedge clk);
    disp_rd = 1'b0;
    repeat (3) @(negedge clk);

    // fetch strobe outside active video is ignored
    disp_active = 1'b0;
    rd(3, 0, 1'b0);
    repeat (2) @(negedge clk);
    disp_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk("ignored_rd_err", err, 0);

    // fill FIFO with window closed, then drain
    wpush(799, 599, 8'h5A);
    wpush(0, 0, 8'h11);
    wpush(1, 0, 8'h22);
    wpush(10, 2, 8'h33);
    wpush(20, 0, 8'h44);
    chk("full_after4", wr_ready, 0);
`ifdef VGA_ARB_STATS_EN
    chk("stall_cnt", stall_cnt, 1);
`endif
    repeat (3) @(negedge clk);
    chk("no_write_closed", 32'(wq.size()), 4);
    wr_window = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wq.size() == 0) break;
    end
    chk("drain_done", 32'(wq.size()), 0);
    repeat (3) @(negedge clk);
    mcnt = 0;
    chk("drained_ready", wr_ready, 1);
    chk("mem_239999_hi", mem[239999][15:8], 8'h5A);
    chk("mem_0", mem[0], 16'h2211);
    chk("mem_805_lo", mem[805][7:0], 8'h33);

    // out-of-range write is discarded without an SRAM cycle
    wpush(800, 0, 8'h99);
    repeat (8) @(negedge clk);
    mcnt = 0;
    chk("oor_ready", wr_ready, 1);
`ifdef VGA_ARB_STATS_EN
    chk("drop_cnt", drop_cnt, 1);
`endif

    // display strobe during the write pulse
    wpush(4, 0, 8'h77);
    wait_we();
    mcnt = 0;
    disp_active = 1'b1;
    wr_window   = 1'b0;
    rd(3, 0, 1'b1);
    @(negedge clk);
    disp_rd = 1'b0;
    chk("collision_set", err, 1);
    repeat (4) @(negedge clk);
    chk("collision_sticky", err, 1);
    chk("mem_2_lo", mem[2][7:0], 8'h77);

    // reset in the middle of a write
    disp_active = 1'b0;
    wpush(10, 0, 8'hAA);
    wpush(12, 0, 8'hBB);
    wr_window = 1'b1;
    wait_we();
    #2 rst_n = 1'b0;
    #1;
    chk("async_we_n", sif.sram_we_n, 1);
    chk("async_dq_oe", sif.sram_dq_oe, 0);
    chk("async_err", err, 0);
    wq.delete();
    rq.delete();
    mcnt = 0;
    wr_window = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", wr_ready, 1);
    wr_window = 1'b1;
    repeat (8) @(negedge clk);
    chk("flushed_oe", sif.sram_dq_oe, 0);
    chk("post_rst_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule

// File: doc/vga_sram_arbiter.md
Name: vga_sram_arbiter

Overview:
- Shares the single 16-bit VGA frame SRAM (256K words, byte-masked high/low lanes) between two requesters.
  - Display pixel-fetch path: fixed latency, absolute priority.
  - Draw/host write path: buffered in a small FIFO, drained only inside a write window supplied by the VGA timing generator.
- Sits between the timing generator and the SRAM pins.
- Replaces ad-hoc enable-based gating with an explicit scheduler.

Parameters:
- H_RES, 800, pixels per line; pixel index = y*H_RES + x.
- V_RES, 600, lines per frame.
- ADDR_W, 18, SRAM word-address width.
- FIFO_DEPTH, 4, write FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- disp_active  in  1  timing generator in active video
- wr_window  in  1  writes may start; generator drops it ≥3 clk before disp_active rises
- disp_rd  in  1  pixel fetch strobe, honoured only when disp_active=1
- disp_x, disp_y  in  10 each  fetch coordinates
- disp_rdata  out  8  fetched pixel
- disp_rvalid  out  1  disp_rdata valid
- wr_req  in  1  write request
- wr_x, wr_y  in  10 each  write coordinates
- wr_data  in  8  write pixel
- wr_ready  out  1  FIFO not full
- sram_addr  out  ADDR_W  word address
- sram_we_n, sram_oe_n  out  1 each  SRAM strobes, active low
- sram_ub_n, sram_lb_n  out  1 each  byte masks, active low
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad driver enable
- sram_dq_in  in  16  read data from pad
- err_collision  out  1  sticky error flag

Behaviour:
- Addressing:
  - idx = y*H_RES + x (19 bit); word = idx[18:1]; lane = idx[0].
  - lane 1 selects the high byte (ub_n=0), lane 0 the low byte (lb_n=0).
  - Coordinates with x≥H_RES or y≥V_RES are out of range: reads return 8'h00; writes are accepted then discarded without an SRAM cycle.
- Reset values (all asynchronous):
  - we_n=1, oe_n=1, ub_n=1, lb_n=1.
  - dq_oe=0, sram_addr=0, dq_out=0.
  - disp_rvalid=0, disp_rdata=0.
  - err_collision=0, FIFO empty, state IDLE.
- Write FIFO:
  - wr_ready = !full; a push occurs when wr_req && wr_ready.
  - Each entry holds precomputed {word, lane, data, oor}.
  - Simultaneous push and pop when full is impossible (wr_ready=0); push and pop when non-full both occur.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
  - IDLE: disp_rd && disp_active → RD. Otherwise, FIFO non-empty && wr_window && !disp_active → WR_SETUP, or a silent pop if the entry is out of range. Display always wins.
  - RD (1 cycle): addr driven, oe_n=0, both masks 0. Next cycle: disp_rdata = selected lane of dq_in, disp_rvalid=1 for one cycle. Read latency is 2 clk from the disp_rd edge. Back-to-back disp_rd every cycle is supported as a pipeline: RD→RD, one result per cycle.
  - WR_SETUP: addr, mask and dq_out driven; dq_oe=1; we_n=1.
  - WR_PULSE: we_n=0.
  - WR_HOLD: we_n=1, dq_oe still 1; pop the FIFO; → IDLE.
  - A write is never aborted once started.
- Collisions:
  - disp_rd during any WR_* state sets err_collision (sticky until reset).
  - The read still produces disp_rvalid at 2-clk latency with disp_rdata=8'h00.
- disp_rd with disp_active=0 is ignored entirely: no rvalid, no error.
- oe_n and we_n are never low in the same cycle; dq_oe=1 only in WR_* states.
- Reset asserted mid-write releases we_n and dq_oe immediately and flushes the FIFO.

Optional Feature:
- Macro: VGA_ARB_STATS_EN.
- Defined:
  - Adds output wr_stall_cnt[15:0], incremented each cycle with wr_req && !wr_ready, saturating at 16'hFFFF, cleared by rst_n.
  - Adds output wr_drop_cnt[7:0], counting out-of-range writes, saturating.
- Undefined: both ports and counters absent; all other behaviour identical.

Test Plan:
- Reset then idle → all strobes high, dq_oe=0, wr_ready=1, disp_rvalid=0.
- disp_active=1, disp_rd at (x=3,y=0), dq_in=16'hAB12 → sram_addr=1, disp_rdata=8'hAB, rvalid exactly 2 clk after the strobe; (x=2,y=0) → addr=1, data 8'h12.
- Push 5 writes with FIFO_DEPTH=4 and wr_window=0 → wr_ready=0 after the 4th. Raise wr_window → four 3-cycle writes, e.g. (799,599,8'h5A) → addr=239999, ub_n=0, lb_n=1, dq_out[15:8]=8'h5A, we_n low exactly one cycle.
- Write to (800,0) → accepted, no we_n pulse, FIFO drains (drop counter +1 when VGA_ARB_STATS_EN).
- Force disp_rd during WR_PULSE → err_collision=1 and stays 1; rvalid with 8'h00 at 2-clk latency.
- Assert rst_n=0 in WR_PULSE → we_n=1 and dq_oe=0 asynchronously, FIFO empty after release.
